// File: rtl/tt_sweep_ctrl_if.sv
// tt_sweep_ctrl_if: control, result and gate-facing signals of the truth-table sweep controller.
interface tt_sweep_ctrl_if;
    logic       start;
    logic       repeat_en;
    logic       abort;
    logic [7:0] expected;
    logic       dut_out;
    logic [2:0] dut_in;
    logic       busy;
    logic       done;
    logic [7:0] tt_code;
    logic       tt_valid;
    logic       match;
    logic [7:0] err_cnt;
    modport master (
        output start, repeat_en, abort, expected, dut_out,
        input  dut_in, busy, done, tt_code, tt_valid, match, err_cnt
    );
    modport slave (
        input  start, repeat_en, abort, expected, dut_out,
        output dut_in, busy, done, tt_code, tt_valid, match, err_cnt
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: steps a 3-input gate through all eight input vectors, samples its output
// after a settle time and publishes the 8-bit truth-table code with match and error count.
module tt_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    tt_sweep_ctrl_if.slave bus
);
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shreg;
    logic [7:0]       assembled;
    logic             last_cnt;
    // vector 0 is sampled first, so after eight shifts it lands in bit 7
    assign assembled = {shreg[6:0], bus.dut_out};
    assign last_cnt  = cnt == CNT_W'(SETTLE_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            bus.dut_in   <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.tt_code  <= '0;
            bus.tt_valid <= 1'b0;
            bus.match    <= 1'b0;
            bus.err_cnt  <= '0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start && !bus.abort) begin
                    state       <= SWEEP;
                    cnt         <= '0;
                    bus.dut_in  <= '0;
                    bus.busy    <= 1'b1;
                    bus.err_cnt <= '0;
                end
            end else if (bus.abort) begin
                state      <= IDLE;
                cnt        <= '0;
                bus.dut_in <= '0;
                bus.busy   <= 1'b0;
            end else if (!last_cnt) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt        <= '0;
                shreg      <= assembled;
                bus.dut_in <= bus.dut_in + 3'd1;
                if (bus.dut_in == 3'd7) begin
                    bus.tt_code  <= assembled;
                    bus.tt_valid <= 1'b1;
                    bus.done     <= 1'b1;
                    bus.match    <= assembled == bus.expected;
                    if (assembled != bus.expected && bus.err_cnt != 8'hFF)
                        bus.err_cnt <= bus.err_cnt + 8'd1;
                    if (!bus.repeat_en) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
